// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encoding, width default and counter sizing for serial_adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must reach WIDTH without wrapping.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_add_cell.sv
// rtl/full_add_cell.sv - one-bit full adder from two half-adder stages and an OR of the carries
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic hs_sum;
    logic hs_carry;
    logic hc_carry;

    assign hs_sum   = a ^ b;
    assign hs_carry = a & b;
    assign sum      = hs_sum ^ cin;
    assign hc_carry = hs_sum & cin;
    assign cout     = hs_carry | hc_carry;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial a+b+cin adder, LSB first; SERIAL_ADDER_OVF_EN adds the signed overflow output ovf
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_sum;
    logic             bit_carry;

    full_add_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    // a_sr doubles as the result register: sum bits enter at the MSB as operand bits leave the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_sr  <= {bit_sum, a_sr[WIDTH-1:1]};
                    b_sr  <= b_sr >> 1;
                    carry <= bit_carry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {bit_sum, a_sr[WIDTH-1:1]};
                        cout  <= bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry here is still the carry into the MSB cell
                        ovf   <= carry ^ bit_carry;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed self-check of serial_adder at WIDTH 8 and 16 (SERIAL_ADDER_OVF_EN aware)
module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic        cin8   = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0;
    logic        cin16   = 1'b0;
    logic [15:0] a16     = '0;
    logic [15:0] b16     = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf8, ovf16;
    logic        exp_ovf;
`endif

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf8),
`endif
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf16),
`endif
        .cout  (cout16)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic        sel16       = 1'b0;
    logic [15:0] exp_sum;
    logic        exp_cout;

    logic        cur_busy, cur_done, cur_cout;
    logic [15:0] cur_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic        cur_ovf;
`endif

    always_comb begin
        cur_busy = sel16 ? busy16 : busy8;
        cur_done = sel16 ? done16 : done8;
        cur_cout = sel16 ? cout16 : cout8;
        cur_sum  = sel16 ? sum16 : {8'h00, sum8};
`ifdef SERIAL_ADDER_OVF_EN
        cur_ovf  = sel16 ? ovf16 : ovf8;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (sel16) begin
            start16 = s; a16 = a; b16 = b; cin16 = c;
        end else begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = c;
        end
    endtask

    // Reference: plain integer addition; overflow from the operand/result sign rule.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c);
        int          w;
        logic [15:0] mask, am, bm;
        logic [32:0] full;
        w    = sel16 ? 16 : 8;
        mask = sel16 ? 16'hFFFF : 16'h00FF;
        am   = a & mask;
        bm   = b & mask;
        full = 33'(am) + 33'(bm) + 33'(c);
        exp_sum  = full[15:0] & mask;
        exp_cout = full[w];
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf  = (am[w-1] == bm[w-1]) && (exp_sum[w-1] != am[w-1]);
`endif
        drive(1'b1, am, bm, c);
    endtask

    // Cycle 0 is the one where start was presented; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int poke);
        int w;
        int lat;
        int busy_cycles;
        w           = sel16 ? 16 : 8;
        busy_cycles = 0;
        @(negedge clk);
        lat = 1;
        while (!cur_done && lat <= w + 4) begin
            if (cur_busy) busy_cycles++;
            if (lat == poke) drive(1'b1, 16'($urandom), 16'($urandom), 1'b1);
            else             drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(w + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(w));
        check({tag, "_sum"}, 32'(cur_sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cur_cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(cur_ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic finish_op(input string tag);
        drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        @(negedge clk);
        check({tag, "_done_fall"}, 32'(cur_done), 0);
        check({tag, "_idle_busy"}, 32'(cur_busy), 0);
    endtask

    initial begin
        int dones;

        #12;
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_sum8", 32'(sum8), 0);
        check("rst_cout8", 32'(cout8), 0);
        check("rst_sum16", 32'(sum16), 0);

        @(negedge clk);
        rst_n = 1'b1;
        sel16 = 1'b0;
        launch(16'h0F, 16'h01, 1'b0);
        wait_done("r27", 0);
        check("r27_const", 32'(cur_sum), 'h10);
        finish_op("r27");

        launch(16'hFF, 16'h01, 1'b0);
        wait_done("r28a", 0);
        check("r28a_const", 32'(cur_cout), 1);
        finish_op("r28a");
        launch(16'h7F, 16'h01, 1'b0);
        wait_done("r28b", 0);
        check("r28b_const", 32'(cur_sum), 'h80);
        finish_op("r28b");

        launch(16'h00, 16'h00, 1'b1);
        wait_done("r29a", 0);
        launch(16'h55, 16'hAA, 1'b1);
        wait_done("r29b", 0);
        check("r29b_const", 32'(cur_sum), 0);
        finish_op("r29b");

        launch(16'h12, 16'h34, 1'b0);
        wait_done("r30", 3);
        finish_op("r30");
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (cur_done) dones++;
        end
        check("r30_extra_done", 32'(dones), 0);

        launch(16'hC3, 16'h5A, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("r31_busy", 32'(busy8), 0);
        check("r31_done", 32'(done8), 0);
        check("r31_sum", 32'(sum8), 0);
        check("r31_cout", 32'(cout8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (cur_done || cur_busy) dones++;
        end
        check("r31_no_done", 32'(dones), 0);
        launch(16'hC3, 16'h5A, 1'b1);
        wait_done("r31_after", 0);
        finish_op("r31_after");

        for (int i = 0; i < 1000; i++) begin
            launch(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done("rand8", 0);
            if ($urandom_range(3) != 0) finish_op("rand8");
        end
        finish_op("rand8_end");

        sel16 = 1'b1;
        @(negedge clk);
        launch(16'hFFFF, 16'h0001, 1'b0);
        wait_done("w16_wrap", 0);
        finish_op("w16_wrap");
        launch(16'h7FFF, 16'h0000, 1'b1);
        wait_done("w16_ovf", 0);
        finish_op("w16_ovf");
        for (int i = 0; i < 1000; i++) begin
            launch(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done("rand16", 0);
            if ($urandom_range(3) != 0) finish_op("rand16");
        end
        finish_op("rand16_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
